// File: rtl/cdp1802_uart_pkg.sv
// cdp1802_uart_pkg: port numbers, status/EF bit positions and FSM states for the cdp1802 UART
package cdp1802_uart_pkg;
  localparam logic [2:0] PORT_DATA = 3'd1;
  localparam logic [2:0] PORT_STAT = 3'd2;
  localparam int ST_RX_AVAIL = 0;
  localparam int ST_TX_READY = 1;
  localparam int ST_RX_OVR = 2;
  localparam int ST_RX_FERR = 3;
  localparam int ST_TX_OVR = 4;
  localparam int EF_RX_AVAIL = 0;
  localparam int EF_TX_READY = 1;
  localparam int EF_RX_FERR = 2;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} fsm_e;
endpackage

// File: rtl/cdp1802_uart_rx.sv
// cdp1802_uart_rx: 8N1 receiver with 2-flop synchroniser; emits byte with a valid or framing-error pulse
module cdp1802_uart_rx
  import cdp1802_uart_pkg::*;
#(
  parameter logic [15:0] CLKS_PER_BIT = 16'd868
) (
  input  logic       clock,
  input  logic       resetq,
  input  logic       uart_rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       ferr
);
  fsm_e state, next;
  logic s1, s2, sp;
  logic [15:0] cnt;
  logic [2:0] idx;
  logic [7:0] shift;
  logic bit_end, half_end;
  assign bit_end = cnt == CLKS_PER_BIT - 16'd1;
  assign half_end = cnt == (CLKS_PER_BIT >> 1) - 16'd1;
  assign data = shift;
  always_ff @(posedge clock or negedge resetq)
    if (!resetq) state <= IDLE;
    else state <= next;
  // a start bit still high at its midpoint is treated as a glitch
  always_comb
    next = (state == IDLE)  ? ((sp && !s2) ? START : IDLE) :
           (state == START) ? (half_end ? (s2 ? IDLE : DATA) : START) :
           (state == DATA)  ? ((bit_end && idx == 3'd7) ? STOP : DATA) :
                              (bit_end ? IDLE : STOP);
  always_comb begin
    valid = state == STOP && bit_end && s2;
    ferr = state == STOP && bit_end && !s2;
  end
  always_ff @(posedge clock or negedge resetq)
    if (!resetq) begin
      {s1, s2, sp} <= 3'b111;
      cnt <= '0;
      idx <= '0;
      shift <= '0;
    end else begin
      {s1, s2, sp} <= {uart_rx, s1, s2};
      cnt <= (next != state || bit_end) ? 16'd0 : cnt + 16'd1;
      if (state == START) idx <= '0;
      else if (state == DATA && bit_end) idx <= idx + 3'd1;
      if (state == DATA && bit_end) shift <= {s2, shift[7:1]};
    end
endmodule

// File: rtl/cdp1802_uart.sv
// cdp1802_uart: polled 8N1 UART on the cdp1802 I/O port (OUT1/INP1 data, OUT2 clear, INP2 status).
// Define CDP1802_UART_RXFIFO_EN for a 4-entry RX FIFO instead of a single holding register.
module cdp1802_uart
  import cdp1802_uart_pkg::*;
#(
  parameter logic [15:0] CLKS_PER_BIT = 16'd868
) (
  input  logic       clock,
  input  logic       resetq,
  input  logic [2:0] io_n,
  input  logic       io_inp,
  input  logic       io_out,
  input  logic [7:0] io_dout,
  output logic [7:0] io_din,
  output logic [3:0] ef,
  input  logic       uart_rx,
  output logic       uart_tx
);
  fsm_e tx_state, tx_next;
  logic [15:0] tx_cnt;
  logic [2:0] tx_idx;
  logic [7:0] tx_shift, tx_hold, rx_byte, rx_dout, stat;
  logic tx_full, tx_ovr, tx_bit_end, tx_load;
  logic rx_valid, rx_ferr_p, rx_avail, rx_pop, rx_push, rx_ovr_ev, rx_ovr, rx_ferr;
  logic wr_data, wr_clr, rd_data;
  assign wr_data = io_out && io_n == PORT_DATA;
  assign wr_clr = io_out && io_n == PORT_STAT;
  assign rd_data = io_inp && io_n == PORT_DATA;
  assign tx_bit_end = tx_cnt == CLKS_PER_BIT - 16'd1;
  // loading at end of STOP gives gap-free back-to-back frames
  assign tx_load = tx_full && (tx_state == IDLE || (tx_state == STOP && tx_bit_end));
  always_ff @(posedge clock or negedge resetq)
    if (!resetq) tx_state <= IDLE;
    else tx_state <= tx_next;
  always_comb
    tx_next = (tx_state == IDLE)  ? (tx_full ? START : IDLE) :
              (tx_state == START) ? (tx_bit_end ? DATA : START) :
              (tx_state == DATA)  ? ((tx_bit_end && tx_idx == 3'd7) ? STOP : DATA) :
                                    (tx_bit_end ? (tx_full ? START : IDLE) : STOP);
  always_comb
    uart_tx = (tx_state == START) ? 1'b0 : (tx_state == DATA) ? tx_shift[0] : 1'b1;
  always_ff @(posedge clock or negedge resetq)
    if (!resetq) begin
      tx_cnt <= '0;
      tx_idx <= '0;
      tx_shift <= '0;
      tx_hold <= '0;
      tx_full <= 1'b0;
      tx_ovr <= 1'b0;
      rx_ovr <= 1'b0;
      rx_ferr <= 1'b0;
    end else begin
      tx_cnt <= (tx_next != tx_state || tx_bit_end) ? 16'd0 : tx_cnt + 16'd1;
      if (tx_load) tx_idx <= '0;
      else if (tx_state == DATA && tx_bit_end) tx_idx <= tx_idx + 3'd1;
      if (tx_load) tx_shift <= tx_hold;
      else if (tx_state == DATA && tx_bit_end) tx_shift <= tx_shift >> 1;
      if (wr_data && (!tx_full || tx_load)) tx_hold <= io_dout;
      tx_full <= wr_data || (tx_full && !tx_load);
      tx_ovr <= (wr_data && tx_full && !tx_load) || (tx_ovr && !wr_clr);
      rx_ovr <= rx_ovr_ev || (rx_ovr && !wr_clr);
      rx_ferr <= rx_ferr_p || (rx_ferr && !wr_clr);
    end
  cdp1802_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clock  (clock),
    .resetq (resetq),
    .uart_rx(uart_rx),
    .data   (rx_byte),
    .valid  (rx_valid),
    .ferr   (rx_ferr_p)
  );
`ifdef CDP1802_UART_RXFIFO_EN
  logic [7:0] fifo [4];
  logic [1:0] wp, rp;
  logic [2:0] cnt;
  assign rx_avail = cnt != 3'd0;
  assign rx_pop = rd_data && rx_avail;
  assign rx_push = rx_valid && (cnt != 3'd4 || rx_pop);
  assign rx_ovr_ev = rx_valid && cnt == 3'd4 && !rx_pop;
  assign rx_dout = rx_avail ? fifo[rp] : 8'h00;
  always_ff @(posedge clock)
    if (rx_push) fifo[wp] <= rx_byte;
  always_ff @(posedge clock or negedge resetq)
    if (!resetq) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (rx_push) wp <= wp + 2'd1;
      if (rx_pop) rp <= rp + 2'd1;
      cnt <= cnt + {2'b0, rx_push} - {2'b0, rx_pop};
    end
`else
  logic [7:0] rx_hold;
  logic rx_full;
  assign rx_avail = rx_full;
  assign rx_pop = rd_data && rx_full;
  assign rx_push = rx_valid && (!rx_full || rx_pop);
  assign rx_ovr_ev = rx_valid && rx_full && !rx_pop;
  assign rx_dout = rx_hold;
  always_ff @(posedge clock or negedge resetq)
    if (!resetq) begin
      rx_hold <= '0;
      rx_full <= 1'b0;
    end else begin
      if (rx_push) rx_hold <= rx_byte;
      rx_full <= rx_push || (rx_full && !rx_pop);
    end
`endif
  always_comb begin
    stat = '0;
    stat[ST_RX_AVAIL] = rx_avail;
    stat[ST_TX_READY] = !tx_full;
    stat[ST_RX_OVR] = rx_ovr;
    stat[ST_RX_FERR] = rx_ferr;
    stat[ST_TX_OVR] = tx_ovr;
    io_din = (io_n == PORT_DATA) ? rx_dout : (io_n == PORT_STAT) ? stat : 8'h00;
    ef = '0;
    ef[EF_RX_AVAIL] = rx_avail;
    ef[EF_TX_READY] = !tx_full;
    ef[EF_RX_FERR] = rx_ferr;
  end
endmodule
